// File: rtl/data_bus_responder.sv
// CPU data-port responder: decodes each access to RAM, the MMIO register window or unmapped space.
// Reads are combinational from addr and writes commit at posedge, matching the RAM's own timing.
module data_bus_responder #(
    parameter int unsigned RAM_AW    = 8,
    parameter logic [31:0] MMIO_BASE = 32'h0000_7F00,
    parameter logic [31:0] RAM_LIMIT = 32'h0000_0400
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_a,
    output logic [31:0]       ram_d,
    input  logic [31:0]       ram_spo,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              irq_timer
);

    localparam logic [5:0] REG_LED    = 6'h00;
    localparam logic [5:0] REG_SW     = 6'h01;
    localparam logic [5:0] REG_CYC_LO = 6'h02;
    localparam logic [5:0] REG_CYC_HI = 6'h03;
    localparam logic [5:0] REG_CMP    = 6'h04;
    localparam logic [5:0] REG_CTRL   = 6'h05;
    localparam logic [5:0] REG_CNT    = 6'h06;

    logic        ram_hit;
    logic        mmio_hit;
    logic [5:0]  reg_idx;

    logic        wr_led;
    logic        wr_cmp;
    logic        wr_ctrl;
    logic        wr_cnt;
    logic        rd_cyc_lo;

    logic [15:0] sw_sync_p0;
    logic [15:0] sw_sync_p1;
    logic [63:0] cycle;
    logic [31:0] hi_snap;

    logic [31:0] tmr_cmp;
    logic [31:0] tmr_cnt;
    logic [31:0] cnt_next;
    logic        tmr_en;
    logic        tmr_auto;
    logic        tmr_match;
    logic        cnt_hit;
    logic        match_clr;
    logic        match_next;

    assign ram_hit  = (addr < RAM_LIMIT);
    assign mmio_hit = (addr[31:8] == MMIO_BASE[31:8]);
    assign reg_idx  = addr[7:2];

    assign wr_led    = we && mmio_hit && (reg_idx == REG_LED);
    assign wr_cmp    = we && mmio_hit && (reg_idx == REG_CMP);
    assign wr_ctrl   = we && mmio_hit && (reg_idx == REG_CTRL);
    assign wr_cnt    = we && mmio_hit && (reg_idx == REG_CNT);
    assign rd_cyc_lo = !we && mmio_hit && (reg_idx == REG_CYC_LO);

    // RAM writes are suppressed while reset is held so a stray strobe cannot corrupt memory.
    assign ram_we = we && ram_hit && rstn;
    assign ram_a  = addr[RAM_AW+1:2];
    assign ram_d  = wdata;

    // Match compares the pre-write count; a CPU count write only replaces the next value.
    assign cnt_hit    = tmr_en && (tmr_cnt == tmr_cmp);
    assign match_clr  = wr_ctrl && wdata[2];
    assign match_next = cnt_hit || (tmr_match && !match_clr);

    always_comb begin
        cnt_next = tmr_cnt;
        if (wr_cnt) begin
            cnt_next = wdata;
        end else if (tmr_en) begin
            cnt_next = (cnt_hit && tmr_auto) ? 32'd0 : tmr_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            led_out    <= '0;
            sw_sync_p0 <= '0;
            sw_sync_p1 <= '0;
            cycle      <= '0;
            hi_snap    <= '0;
            tmr_cmp    <= 32'hFFFF_FFFF;
            tmr_cnt    <= '0;
            tmr_en     <= 1'b0;
            tmr_auto   <= 1'b0;
            tmr_match  <= 1'b0;
        end else begin
            sw_sync_p0 <= sw_in;
            sw_sync_p1 <= sw_sync_p0;
            cycle      <= cycle + 64'd1;
            // Snapshot the upper half alongside a CYCLE_LO read so the pair is coherent.
            if (rd_cyc_lo) begin
                hi_snap <= cycle[63:32];
            end
            if (wr_led) begin
                led_out <= wdata[15:0];
            end
            if (wr_cmp) begin
                tmr_cmp <= wdata;
            end
            if (wr_ctrl) begin
                tmr_en   <= wdata[0];
                tmr_auto <= wdata[1];
            end
            tmr_cnt   <= cnt_next;
            tmr_match <= match_next;
        end
    end

    assign irq_timer = tmr_match;

    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = ram_spo;
        end else if (mmio_hit) begin
            case (reg_idx)
                REG_LED:    rdata = {16'd0, led_out};
                REG_SW:     rdata = {16'd0, sw_sync_p1};
                REG_CYC_LO: rdata = cycle[31:0];
                REG_CYC_HI: rdata = hi_snap;
                REG_CMP:    rdata = tmr_cmp;
                REG_CTRL:   rdata = {29'd0, tmr_match, tmr_auto, tmr_en};
                REG_CNT:    rdata = tmr_cnt;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed scenarios plus randomized traffic against a register-level model.
module tb_data_bus_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ram_we;
    logic [7:0]  ram_a;
    logic [31:0] ram_d;
    logic [31:0] ram_spo;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic        irq_timer;

    int checks = 0;
    int failures = 0;

    data_bus_responder #(
        .RAM_AW(8),
        .MMIO_BASE(32'h0000_7F00),
        .RAM_LIMIT(32'h0000_0400)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .we(we),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .ram_we(ram_we),
        .ram_a(ram_a),
        .ram_d(ram_d),
        .ram_spo(ram_spo),
        .sw_in(sw_in),
        .led_out(led_out),
        .irq_timer(irq_timer)
    );

    always #5 clk = ~clk;

    // Distributed RAM stub driven purely by the DUT's RAM port.
    logic [31:0] ram_mem [256];
    assign ram_spo = ram_mem[ram_a];
    always @(posedge clk) if (ram_we) ram_mem[ram_a] <= ram_d;

    // Reference model: architectural state of the memory map, updated from bus activity.
    logic [31:0] m_mem [256];
    logic [15:0] m_led, m_sw1, m_sw2;
    logic [63:0] m_cycle;
    logic [31:0] m_hi, m_cmp, m_cnt;
    logic        m_en, m_ar, m_match;
    logic        m_mm, m_hit;
    logic [7:0]  m_off;

    assign m_mm  = (addr[31:8] == 24'h00007F);
    assign m_off = {addr[7:2], 2'b00};
    assign m_hit = m_en && (m_cnt == m_cmp);

    always @(posedge clk) begin
        if (!rstn) begin
            m_led <= '0; m_sw1 <= '0; m_sw2 <= '0; m_cycle <= '0; m_hi <= '0;
            m_cmp <= 32'hFFFF_FFFF; m_cnt <= '0; m_en <= 1'b0; m_ar <= 1'b0; m_match <= 1'b0;
        end else begin
            m_cycle <= m_cycle + 64'd1;
            m_sw1 <= sw_in;
            m_sw2 <= m_sw1;
            if (!we && m_mm && m_off == 8'h08) m_hi <= m_cycle[63:32];
            if (we && addr < 32'h400) m_mem[addr[9:2]] <= wdata;
            if (we && m_mm && m_off == 8'h00) m_led <= wdata[15:0];
            if (we && m_mm && m_off == 8'h10) m_cmp <= wdata;
            if (we && m_mm && m_off == 8'h14) begin
                m_en <= wdata[0];
                m_ar <= wdata[1];
            end
            if (we && m_mm && m_off == 8'h18) m_cnt <= wdata;
            else if (m_en) m_cnt <= (m_hit && m_ar) ? 32'd0 : m_cnt + 32'd1;
            m_match <= m_hit || (m_match && !(we && m_mm && m_off == 8'h14 && wdata[2]));
        end
    end

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        logic [7:0] off;
        off = {a[7:2], 2'b00};
        if (a < 32'h400) return m_mem[a[9:2]];
        if (a[31:8] != 24'h00007F) return 32'd0;
        case (off)
            8'h00: return {16'd0, m_led};
            8'h04: return {16'd0, m_sw2};
            8'h08: return m_cycle[31:0];
            8'h0C: return m_hi;
            8'h10: return m_cmp;
            8'h14: return {29'd0, m_match, m_ar, m_en};
            8'h18: return m_cnt;
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; sw_in = 16'h0;
        tick(); tick();
        checks++; if (led_out !== 16'h0) begin failures++; $display("FAIL reset_led got=%h exp=0000", led_out); end
        checks++; if (irq_timer !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_timer); end
        addr = 32'h7F10; #1;
        checks++; if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp got=%h exp=ffffffff", rdata); end
        addr = 32'h7F18; #1;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", rdata); end
        addr = 32'h7F08; #1;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_cycle got=%h exp=0", rdata); end
        rstn = 1'b1;
    endtask

    task automatic test_ram();
        logic [31:0] a, d;
        we = 1'b1; addr = 32'h10; wdata = 32'h1234_5678; #1;
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL ram_we_on got=%b exp=1", ram_we); end
        checks++; if (ram_a !== 8'd4) begin failures++; $display("FAIL ram_a got=%0d exp=4", ram_a); end
        checks++; if (ram_d !== 32'h1234_5678) begin failures++; $display("FAIL ram_d got=%h exp=12345678", ram_d); end
        tick();
        we = 1'b0; #1;
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL ram_we_off got=%b exp=0", ram_we); end
        checks++; if (rdata !== 32'h1234_5678) begin failures++; $display("FAIL ram_read got=%h exp=12345678", rdata); end
        addr = 32'h9000; #1;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", rdata); end
        we = 1'b1; wdata = 32'hDEAD_0001; addr = 32'h400; #1;
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL ram_limit_we got=%b exp=0", ram_we); end
        addr = 32'h3FC; #1;
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL ram_top_we got=%b exp=1", ram_we); end
        tick();
        we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a = {22'd0, 8'($urandom), 2'b00};
            d = $urandom;
            wr(a, d);
            addr = a; #1;
            checks++; if (rdata !== d) begin failures++; $display("FAIL ram_rand addr=%h got=%h exp=%h", a, rdata, d); end
        end
    endtask

    task automatic test_led_sw();
        wr(32'h7F00, 32'hFFFF_ABCD);
        checks++; if (led_out !== 16'hABCD) begin failures++; $display("FAIL led_out got=%h exp=abcd", led_out); end
        addr = 32'h7F00; #1;
        checks++; if (rdata !== 32'h0000_ABCD) begin failures++; $display("FAIL led_read got=%h exp=0000abcd", rdata); end
        sw_in = 16'h00F0; addr = 32'h7F04; #1;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL sw_lat0 got=%h exp=0", rdata); end
        tick();
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL sw_lat1 got=%h exp=0", rdata); end
        tick();
        checks++; if (rdata !== 32'h0000_00F0) begin failures++; $display("FAIL sw_lat2 got=%h exp=000000f0", rdata); end
    endtask

    task automatic test_cycle();
        logic [31:0] first;
        addr = 32'h7F08; #1;
        first = rdata;
        checks++; if (rdata !== m_cycle[31:0]) begin failures++; $display("FAIL cycle_lo got=%h exp=%h", rdata, m_cycle[31:0]); end
        tick();
        checks++; if (rdata !== first + 32'd1) begin failures++; $display("FAIL cycle_step got=%h exp=%h", rdata, first + 32'd1); end
        addr = 32'h7F0C; #1;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL cycle_hi got=%h exp=0", rdata); end
        wr(32'h7F08, 32'h0);
        addr = 32'h7F08; #1;
        checks++; if (rdata !== m_cycle[31:0] || rdata < 32'd10) begin failures++; $display("FAIL cycle_ro got=%h exp=%h", rdata, m_cycle[31:0]); end
    endtask

    task automatic test_timer_reload();
        wr(32'h7F10, 32'd5);
        wr(32'h7F18, 32'd0);
        wr(32'h7F14, 32'd3);
        addr = 32'h7F18;
        repeat (5) tick();
        checks++; if (irq_timer !== 1'b0 || rdata !== 32'd5) begin failures++; $display("FAIL tmr_pre irq=%b cnt=%0d exp irq=0 cnt=5", irq_timer, rdata); end
        tick();
        checks++; if (irq_timer !== 1'b1 || rdata !== 32'd0) begin failures++; $display("FAIL tmr_match irq=%b cnt=%0d exp irq=1 cnt=0", irq_timer, rdata); end
        wr(32'h7F14, 32'd7);
        addr = 32'h7F18; #1;
        checks++; if (irq_timer !== 1'b0 || rdata !== 32'd1) begin failures++; $display("FAIL tmr_clear irq=%b cnt=%0d exp irq=0 cnt=1", irq_timer, rdata); end
        repeat (4) tick();
        checks++; if (irq_timer !== 1'b0) begin failures++; $display("FAIL tmr_rearm_early got=%b exp=0", irq_timer); end
        tick();
        checks++; if (irq_timer !== 1'b1) begin failures++; $display("FAIL tmr_rearm got=%b exp=1", irq_timer); end
    endtask

    task automatic test_w1c_collision();
        wr(32'h7F10, 32'd50);
        wr(32'h7F18, 32'd48);
        wr(32'h7F14, 32'd7);
        checks++; if (irq_timer !== 1'b0) begin failures++; $display("FAIL w1c_plain got=%b exp=0", irq_timer); end
        tick();
        addr = 32'h7F18; #1;
        checks++; if (rdata !== 32'd50) begin failures++; $display("FAIL w1c_setup cnt=%0d exp=50", rdata); end
        wr(32'h7F14, 32'd7);
        checks++; if (irq_timer !== 1'b1) begin failures++; $display("FAIL w1c_collision got=%b exp=1", irq_timer); end
        wr(32'h7F18, 32'd100);
        addr = 32'h7F18; #1;
        checks++; if (rdata !== 32'd100) begin failures++; $display("FAIL cnt_write got=%0d exp=100", rdata); end
        tick();
        checks++; if (rdata !== 32'd101) begin failures++; $display("FAIL cnt_after_write got=%0d exp=101", rdata); end
    endtask

    task automatic test_reset_mid();
        wr(32'h0000_0020, 32'hAAAA_5555);
        wr(32'h7F00, 32'h0000_FFFF);
        checks++; if (led_out !== 16'hFFFF) begin failures++; $display("FAIL mid_led_pre got=%h exp=ffff", led_out); end
        rstn = 1'b0; we = 1'b1; addr = 32'h20; wdata = 32'hDEAD_BEEF; #1;
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL mid_ram_we got=%b exp=0", ram_we); end
        checks++; if (rdata !== 32'hAAAA_5555) begin failures++; $display("FAIL mid_rdata got=%h exp=aaaa5555", rdata); end
        tick();
        rstn = 1'b1; we = 1'b0; #1;
        checks++; if (led_out !== 16'h0 || irq_timer !== 1'b0) begin failures++; $display("FAIL mid_outs led=%h irq=%b exp led=0000 irq=0", led_out, irq_timer); end
        checks++; if (rdata !== 32'hAAAA_5555) begin failures++; $display("FAIL mid_ram_kept got=%h exp=aaaa5555", rdata); end
        addr = 32'h7F18; #1;
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL mid_cnt got=%h exp=0", rdata); end
        addr = 32'h7F10; #1;
        checks++; if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mid_cmp got=%h exp=ffffffff", rdata); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0: a = 32'h7F00;
                1: a = 32'h7F04;
                2: a = 32'h7F08;
                3: a = 32'h7F0C;
                4: a = 32'h7F10;
                5: a = 32'h7F14;
                6: a = 32'h7F18;
                7: a = 32'h7F00 + {24'd0, 8'($urandom_range(7, 63)), 2'b00} + 32'(i % 4);
                8: a = {22'd0, 8'($urandom), 2'b00};
                default: a = 32'h400 + {$urandom_range(0, 16'hFFFF), 2'b00};
            endcase
            addr = a;
            we = ($urandom_range(0, 2) == 0);
            wdata = (a == 32'h7F10 || a == 32'h7F18) ? $urandom_range(0, 20) : $urandom;
            if ($urandom_range(0, 7) == 0) sw_in = 16'($urandom);
            #1;
            checks++; if (rdata !== exp_rdata(a)) begin failures++; $display("FAIL rand_rdata i=%0d addr=%h got=%h exp=%h", i, a, rdata, exp_rdata(a)); end
            checks++; if (ram_we !== (we && a < 32'h400)) begin failures++; $display("FAIL rand_ram_we i=%0d got=%b exp=%b", i, ram_we, we && a < 32'h400); end
            checks++; if (led_out !== m_led || irq_timer !== m_match) begin failures++; $display("FAIL rand_state i=%0d led=%h/%h irq=%b/%b", i, led_out, m_led, irq_timer, m_match); end
            tick();
        end
        we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = '0;
            m_mem[i] = '0;
        end
        test_reset();
        test_ram();
        test_led_sw();
        test_cycle();
        test_timer_reload();
        test_w1c_collision();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
